phys_reg_read_stage: RTL and testbench

//  Parametrised register-read pipeline stage for the out-of-order core. Wraps
//  the physical register file and its busy list.

---
 rtl/phys_reg_read_stage.sv | 164 ++++++++++++++++
 tb/tb_phys_reg_read_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_read_stage.sv
// phys_reg_read_stage
//   Register-read stage between rename/issue and execute. It owns the
//   physical register file and the busy list. Each accepted request reads
//   NUM_READ operands into a registered output slot, one cycle later.
//   Same-cycle write-back data is forwarded into the slot. While the slot is
//   stalled, write-backs that hit a held operand refresh its value and mark
//   it ready.
// Ports
//   CLK, RESET     rising-edge clock, synchronous active-high reset
//   Valid_IN       read request present; RegAddr_IN holds the packed addresses
//   Stall_IN       downstream cannot take the slot; Accept_OUT means request taken
//   Write_IN       per-port write enables; RegWrite_IN and DataWrite_IN are packed
//   SetBusy_IN     marks BusyReg_IN busy (new allocation)
//   Valid_OUT      slot valid; RegValue_OUT and Ready_OUT are per-operand, packed
//   Busy_list_OUT  registered busy bit per physical register
module phys_reg_read_stage #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_READ      = 3,
  parameter int NUM_WRITE     = 2,
  parameter int DATA_WIDTH    = 32,
  parameter bit ZERO_REG      = 1'b1,
  localparam int LOG_PHYS     = $clog2(NUM_PHYS_REGS)
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            Valid_IN,
  input  logic [NUM_READ*LOG_PHYS-1:0]    RegAddr_IN,
  input  logic                            Stall_IN,
  output logic                            Accept_OUT,
  input  logic [NUM_WRITE-1:0]            Write_IN,
  input  logic [NUM_WRITE*LOG_PHYS-1:0]   RegWrite_IN,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] DataWrite_IN,
  input  logic [LOG_PHYS-1:0]             BusyReg_IN,
  input  logic                            SetBusy_IN,
  output logic                            Valid_OUT,
  output logic [NUM_READ*DATA_WIDTH-1:0]  RegValue_OUT,
  output logic [NUM_READ-1:0]             Ready_OUT,
  output logic [NUM_PHYS_REGS-1:0]        Busy_list_OUT
);

  logic [DATA_WIDTH-1:0]          regfile_q [NUM_PHYS_REGS];
  logic [DATA_WIDTH-1:0]          regfile_d [NUM_PHYS_REGS];
  logic [NUM_PHYS_REGS-1:0]       busy_q, busy_d;
  logic                           valid_q, valid_d;
  logic [NUM_READ*LOG_PHYS-1:0]   addr_q, addr_d;
  logic [NUM_READ*DATA_WIDTH-1:0] value_q, value_d;
  logic [NUM_READ-1:0]            ready_q, ready_d;

  logic [NUM_PHYS_REGS-1:0]       wr_hit_s;
  logic [DATA_WIDTH-1:0]          wr_data_s [NUM_PHYS_REGS];
  logic [LOG_PHYS-1:0]            wr_addr_s;
  logic                           wr_en_s;
  logic [NUM_PHYS_REGS-1:0]       busy_set_s;
  logic [LOG_PHYS-1:0]            rd_addr_s;
  logic                           hold_s;
  logic                           accept_s;

  // Register 0 is hard-wired when ZERO_REG is set.
  function automatic logic is_zero_reg(input logic [LOG_PHYS-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  assign hold_s        = valid_q & Stall_IN;
  assign accept_s      = Valid_IN & ~hold_s;
  assign Accept_OUT    = accept_s;
  assign Valid_OUT     = valid_q;
  assign RegValue_OUT  = value_q;
  assign Ready_OUT     = ready_q;
  assign Busy_list_OUT = busy_q;

  // Decode the write ports into a per-register hit/data view. Ports are
  // scanned in ascending order, so the highest port writing a register wins.
  always_comb begin
    wr_hit_s  = '0;
    wr_addr_s = '0;
    wr_en_s   = 1'b0;
    for (int r = 0; r < NUM_PHYS_REGS; r++) begin
      wr_data_s[r] = '0;
    end
    for (int w = 0; w < NUM_WRITE; w++) begin
      wr_addr_s = RegWrite_IN[w*LOG_PHYS +: LOG_PHYS];
      wr_en_s   = Write_IN[w] & ~is_zero_reg(wr_addr_s);
      wr_hit_s[wr_addr_s]  = wr_hit_s[wr_addr_s] | wr_en_s;
      wr_data_s[wr_addr_s] = wr_en_s ? DataWrite_IN[w*DATA_WIDTH +: DATA_WIDTH]
                                     : wr_data_s[wr_addr_s];
    end
  end

  // Register file and busy list next state. The busy set is OR-ed in after
  // the write clear, so a new allocation wins over a same-cycle write-back.
  always_comb begin
    busy_set_s = (SetBusy_IN && !is_zero_reg(BusyReg_IN))
                 ? ({{(NUM_PHYS_REGS-1){1'b0}}, 1'b1} << BusyReg_IN) : '0;
    for (int r = 0; r < NUM_PHYS_REGS; r++) begin
      regfile_d[r] = wr_hit_s[r] ? wr_data_s[r] : regfile_q[r];
    end
    busy_d = (busy_q & ~wr_hit_s) | busy_set_s;
  end

  // Output slot next state: capture with bypass, hold with refresh, or drain.
  // Ready on capture uses the busy list before this cycle's SetBusy_IN.
  always_comb begin
    valid_d   = valid_q;
    addr_d    = addr_q;
    value_d   = value_q;
    ready_d   = ready_q;
    rd_addr_s = '0;
    if (accept_s) begin
      valid_d = 1'b1;
      addr_d  = RegAddr_IN;
      for (int i = 0; i < NUM_READ; i++) begin
        rd_addr_s = RegAddr_IN[i*LOG_PHYS +: LOG_PHYS];
        if (is_zero_reg(rd_addr_s)) begin
          value_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
          ready_d[i] = 1'b1;
        end else if (wr_hit_s[rd_addr_s]) begin
          value_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data_s[rd_addr_s];
          ready_d[i] = 1'b1;
        end else begin
          value_d[i*DATA_WIDTH +: DATA_WIDTH] = regfile_q[rd_addr_s];
          ready_d[i] = ~busy_q[rd_addr_s];
        end
      end
    end else if (hold_s) begin
      valid_d = 1'b1;
      for (int i = 0; i < NUM_READ; i++) begin
        rd_addr_s = addr_q[i*LOG_PHYS +: LOG_PHYS];
        if (wr_hit_s[rd_addr_s]) begin
          value_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data_s[rd_addr_s];
          ready_d[i] = 1'b1;
        end else begin
          value_d[i*DATA_WIDTH +: DATA_WIDTH] = value_q[i*DATA_WIDTH +: DATA_WIDTH];
          ready_d[i] = ready_q[i];
        end
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int r = 0; r < NUM_PHYS_REGS; r++) begin
        regfile_q[r] <= '0;
      end
      busy_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      value_q <= '0;
      ready_q <= '0;
    end else begin
      for (int r = 0; r < NUM_PHYS_REGS; r++) begin
        regfile_q[r] <= regfile_d[r];
      end
      busy_q  <= busy_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_phys_reg_read_stage.sv
// Bench for phys_reg_read_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_phys_reg_read_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Valid_IN;
  logic [17:0] RegAddr_IN;
  logic        Stall_IN;
  logic        Accept_OUT;
  logic [1:0]  Write_IN;
  logic [11:0] RegWrite_IN;
  logic [63:0] DataWrite_IN;
  logic [5:0]  BusyReg_IN;
  logic        SetBusy_IN;
  logic        Valid_OUT;
  logic [95:0] RegValue_OUT;
  logic [2:0]  Ready_OUT;
  logic [63:0] Busy_list_OUT;

  phys_reg_read_stage dut (
    .CLK(CLK), .RESET(RESET), .Valid_IN(Valid_IN), .RegAddr_IN(RegAddr_IN),
    .Stall_IN(Stall_IN), .Accept_OUT(Accept_OUT), .Write_IN(Write_IN),
    .RegWrite_IN(RegWrite_IN), .DataWrite_IN(DataWrite_IN),
    .BusyReg_IN(BusyReg_IN), .SetBusy_IN(SetBusy_IN), .Valid_OUT(Valid_OUT),
    .RegValue_OUT(RegValue_OUT), .Ready_OUT(Ready_OUT),
    .Busy_list_OUT(Busy_list_OUT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mregs [64];
  logic [63:0] mbusy;
  logic        mvalid;
  int          maddr [3];
  logic [31:0] mval [3];
  logic [2:0]  mrdy;
  bit          hitv [64];
  logic [31:0] hitd [64];
  int          ma;
  bit          mhold;

  always @(posedge CLK) begin
    if (RESET) begin
      for (int r = 0; r < 64; r++) mregs[r] = 32'h0;
      mbusy = 64'h0;
      mvalid = 1'b0;
      mrdy = 3'b000;
      for (int i = 0; i < 3; i++) begin maddr[i] = 0; mval[i] = 32'h0; end
    end else begin
      // which register each write-back lands in this cycle (later port overrides)
      for (int r = 0; r < 64; r++) begin hitv[r] = 1'b0; hitd[r] = 32'h0; end
      for (int w = 0; w < 2; w++) begin
        ma = RegWrite_IN[w*6 +: 6];
        if (Write_IN[w] && ma != 0) begin
          hitv[ma] = 1'b1;
          hitd[ma] = DataWrite_IN[w*32 +: 32];
        end
      end
      mhold = mvalid && Stall_IN;
      if (Valid_IN && !mhold) begin
        mvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
          ma = RegAddr_IN[i*6 +: 6];
          maddr[i] = ma;
          if (ma == 0) begin mval[i] = 32'h0; mrdy[i] = 1'b1; end
          else if (hitv[ma]) begin mval[i] = hitd[ma]; mrdy[i] = 1'b1; end
          else begin mval[i] = mregs[ma]; mrdy[i] = !mbusy[ma]; end
        end
      end else if (mhold) begin
        for (int i = 0; i < 3; i++) begin
          if (hitv[maddr[i]]) begin mval[i] = hitd[maddr[i]]; mrdy[i] = 1'b1; end
        end
      end else begin
        mvalid = 1'b0;
      end
      for (int r = 0; r < 64; r++) begin
        if (hitv[r]) begin mregs[r] = hitd[r]; mbusy[r] = 1'b0; end
      end
      if (SetBusy_IN && BusyReg_IN != 6'd0) mbusy[BusyReg_IN] = 1'b1;
    end
  end

  // Compare process: registered outputs at the falling edge, then the
  // combinational accept once the next inputs have been driven.
  always @(negedge CLK) begin
    if (checking) begin
      chk("valid", Valid_OUT, mvalid);
      chk("values", RegValue_OUT, {mval[2], mval[1], mval[0]});
      chk("ready", Ready_OUT, mrdy);
      chk("busy", Busy_list_OUT, mbusy);
      #2;
      chk("accept", Accept_OUT, Valid_IN && !(mvalid && Stall_IN));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    Valid_IN = 1'b0; RegAddr_IN = 18'h0; Stall_IN = 1'b0;
    Write_IN = 2'b00; RegWrite_IN = 12'h0; DataWrite_IN = 64'h0;
    BusyReg_IN = 6'd0; SetBusy_IN = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [5:0] pick();
    return ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
  endfunction

  initial begin
    idle();
    RESET = 1'b1;
    step();
    checking = 1'b1;
    RESET = 1'b0;
    // 1: reset state
    chk("t1_valid", Valid_OUT, 1'b0);
    chk("t1_busy", Busy_list_OUT, 64'h0);
    chk("t1_values", RegValue_OUT, 96'h0);
    chk("t1_ready", Ready_OUT, 3'b000);

    // 2: write reg5, then read {5,0,7}
    Write_IN = 2'b01; RegWrite_IN = {6'd0, 6'd5}; DataWrite_IN = {32'h0, 32'hDEADBEEF};
    step();
    idle(); Valid_IN = 1'b1; RegAddr_IN = {6'd7, 6'd0, 6'd5};
    step();
    chk("t2_valid", Valid_OUT, 1'b1);
    chk("t2_values", RegValue_OUT, {32'h0, 32'h0, 32'hDEADBEEF});
    chk("t2_ready", Ready_OUT, 3'b111);

    // 3: both ports write reg9, highest port wins, bypassed into the read
    idle(); Valid_IN = 1'b1; RegAddr_IN = {6'd0, 6'd0, 6'd9};
    Write_IN = 2'b11; RegWrite_IN = {6'd9, 6'd9}; DataWrite_IN = {32'h22, 32'h11};
    step();
    chk("t3_bypass", RegValue_OUT[31:0], 32'h22);
    chk("t3_ready", Ready_OUT[0], 1'b1);
    idle(); Valid_IN = 1'b1; RegAddr_IN = {6'd0, 6'd0, 6'd9};
    step();
    chk("t3_later", RegValue_OUT[31:0], 32'h22);

    // 4: busy reg12 read, then refresh while stalled
    idle(); SetBusy_IN = 1'b1; BusyReg_IN = 6'd12;
    step();
    idle(); Valid_IN = 1'b1; RegAddr_IN = {6'd0, 6'd0, 6'd12};
    step();
    chk("t4_notready", Ready_OUT[0], 1'b0);
    chk("t4_busy", Busy_list_OUT[12], 1'b1);
    idle(); Stall_IN = 1'b1;
    Write_IN = 2'b10; RegWrite_IN = {6'd12, 6'd0}; DataWrite_IN = {32'h55, 32'h0};
    step();
    chk("t4_hold", Valid_OUT, 1'b1);
    chk("t4_refresh", RegValue_OUT[31:0], 32'h55);
    chk("t4_ready", Ready_OUT[0], 1'b1);
    chk("t4_cleared", Busy_list_OUT[12], 1'b0);

    // 5: set busy and write the same reg in one cycle
    idle(); Valid_IN = 1'b1; RegAddr_IN = {6'd0, 6'd0, 6'd3};
    SetBusy_IN = 1'b1; BusyReg_IN = 6'd3;
    Write_IN = 2'b01; RegWrite_IN = {6'd0, 6'd3}; DataWrite_IN = {32'h0, 32'hA5A5A5A5};
    step();
    chk("t5_busy", Busy_list_OUT[3], 1'b1);
    chk("t5_value", RegValue_OUT, {64'h0, 32'hA5A5A5A5});
    chk("t5_ready", Ready_OUT, 3'b111);

    // 6: stalled slot refuses a new request; reset clears it
    idle(); Valid_IN = 1'b1; Stall_IN = 1'b1; RegAddr_IN = {6'd1, 6'd2, 6'd3};
    #1;
    chk("t6_accept", Accept_OUT, 1'b0);
    step();
    chk("t6_valid", Valid_OUT, 1'b1);
    chk("t6_values", RegValue_OUT, {64'h0, 32'hA5A5A5A5});
    chk("t6_ready", Ready_OUT, 3'b111);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("t6_reset_valid", Valid_OUT, 1'b0);
    chk("t6_reset_busy", Busy_list_OUT, 64'h0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      Valid_IN     = ($urandom_range(0, 3) != 0);
      Stall_IN     = ($urandom_range(0, 2) == 0);
      Write_IN     = 2'($urandom_range(0, 3));
      RegWrite_IN  = {pick(), pick()};
      DataWrite_IN = {32'($urandom), 32'($urandom)};
      RegAddr_IN   = {pick(), pick(), pick()};
      SetBusy_IN   = ($urandom_range(0, 2) == 0);
      BusyReg_IN   = pick();
      RESET        = ($urandom_range(0, 299) == 0);
      step();
    end
    idle(); RESET = 1'b0;
    step();
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
